// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// pipe_ctrl_pkg -- state type, register-zero constant and load-use compare for pipe_hazard_ctrl.
// Rev 1.0
package pipe_ctrl_pkg;

   typedef enum logic [0:0] {
      RUN     = 1'b0,
      MD_WAIT = 1'b1
   } md_state_e;

   localparam logic [4:0] REG_ZERO = 5'd0;

   // $zero is never a real destination, so a load into it cannot create a hazard.
   function automatic logic load_use_f(
      input logic       mem_read,
      input logic [4:0] ex_rt,
      input logic [4:0] id_rs,
      input logic [4:0] id_rt,
      input logic       uses_rt
   );
      return mem_read && (ex_rt != REG_ZERO) &&
             ((ex_rt == id_rs) || (uses_rt && (ex_rt == id_rt)));
   endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_md_timer.sv
`default_nettype none
// md_timer -- mult/div occupancy down-counter; done marks the final busy cycle.
// Rev 1.0
module md_timer
   import pipe_ctrl_pkg::*;
#(
   parameter int MD_LATENCY = 32
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load_i,
   input  logic active_i,
   output logic busy_o,
   output logic done_o
);

   localparam int            CW       = $clog2(MD_LATENCY);
   localparam logic [CW-1:0] LOAD_VAL = CW'(MD_LATENCY - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = LOAD_VAL;
      end else if (active_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign busy_o = active_i;
   assign done_o = active_i && (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// pipe_hazard_ctrl -- load-use / branch / mult-div sequencing for the 5-stage MIPS pipeline.
// Rev 1.0
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MD_LATENCY  = 32,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [4:0]             idRs,
   input  logic [4:0]             idRt,
   input  logic                   idUsesRt,
   input  logic                   exMemRead,
   input  logic [4:0]             exRt,
   input  logic                   branchTaken,
   input  logic                   mdStart,
   input  logic                   mdIdReq,
   output logic                   pcWrite,
   output logic                   ifidWrite,
   output logic                   ifidFlush,
   output logic                   idexBubble,
   output logic                   mdBusy,
   output logic                   mdDone,
   output logic [STALL_CNT_W-1:0] stallCnt
);

   md_state_e              state_q;
   logic [STALL_CNT_W-1:0] stall_cnt_q;
   logic [STALL_CNT_W-1:0] stall_cnt_d;

   logic md_load;
   logic md_busy;
   logic md_done;
   logic load_use;
   logic md_hold;
   logic stall;

   assign md_load = (state_q == RUN) && mdStart && !branchTaken;

   md_timer #(
      .MD_LATENCY (MD_LATENCY)
   ) u_md_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_i   (md_load),
      .active_i (state_q == MD_WAIT),
      .busy_o   (md_busy),
      .done_o   (md_done)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
      end else begin
         case (state_q)
            RUN:     if (md_load) state_q <= MD_WAIT;
            MD_WAIT: if (md_done) state_q <= RUN;
            default: state_q <= RUN;
         endcase
      end
   end

   // HI/LO is written at the end of the done cycle, so a waiting reader may advance in it.
   assign load_use = load_use_f(exMemRead, exRt, idRs, idRt, idUsesRt);
   assign md_hold  = md_busy && !md_done && mdIdReq;
   assign stall    = !branchTaken && (load_use || md_hold);

   // Outputs fall back to free-running, no-bubble values while reset is held.
   assign pcWrite    = !rst_n || !stall;
   assign ifidWrite  = !rst_n || !stall;
   assign ifidFlush  = rst_n && branchTaken;
   assign idexBubble = rst_n && (branchTaken || stall);
   assign mdBusy     = rst_n && md_busy;
   assign mdDone     = rst_n && md_done;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stallCnt = stall_cnt_q;

`ifndef SYNTHESIS
   a_no_md_restart: assert property (@(posedge clk) disable iff (!rst_n)
      !((state_q == MD_WAIT) && mdStart));
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// tb_pipe_hazard_ctrl -- vector table, hand sequences and randomized model check for pipe_hazard_ctrl.
// Rev 1.0
module tb_pipe_hazard_ctrl;

   localparam int MD_LAT  = 4;
   localparam int CNT_MAX = 65535;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [4:0]  rs = '0, rt = '0, exRt = '0;
   logic        usesRt = 1'b0, memRd = 1'b0, br = 1'b0, mdS = 1'b0, mdReq = 1'b0;
   logic        pcWrite, ifidWrite, ifidFlush, idexBubble, mdBusy, mdDone;
   logic [15:0] stallCnt;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference state: remaining busy cycles of the unit and the stall tally.
   int m_rem = 0;
   int m_cnt = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(
      .MD_LATENCY  (MD_LAT),
      .STALL_CNT_W (16)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .idRs        (rs),
      .idRt        (rt),
      .idUsesRt    (usesRt),
      .exMemRead   (memRd),
      .exRt        (exRt),
      .branchTaken (br),
      .mdStart     (mdS),
      .mdIdReq     (mdReq),
      .pcWrite     (pcWrite),
      .ifidWrite   (ifidWrite),
      .ifidFlush   (ifidFlush),
      .idexBubble  (idexBubble),
      .mdBusy      (mdBusy),
      .mdDone      (mdDone),
      .stallCnt    (stallCnt)
   );

   typedef struct {
      logic [4:0] rs, rt, ex_rt;
      logic       uses_rt, mem_rd, br;
      logic       e_pc, e_ifid, e_flush, e_bub;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic bit model_stall();
      bit lu, hold;
      lu   = memRd && (exRt != 0) && (exRt == rs || (usesRt && exRt == rt));
      hold = (m_rem > 1) && mdReq;
      return !br && (lu || hold);
   endfunction

   // Called at posedge+1; moves to the falling edge where outputs are stable.
   task automatic settle();
      #4;
   endtask

   task automatic model_check();
      bit s;
      s = model_stall();
      chk("m_pcWrite",    pcWrite,    !s);
      chk("m_ifidWrite",  ifidWrite,  !s);
      chk("m_ifidFlush",  ifidFlush,  br);
      chk("m_idexBubble", idexBubble, br || s);
      chk("m_mdBusy",     mdBusy,     m_rem > 0);
      chk("m_mdDone",     mdDone,     m_rem == 1);
      chk("m_stallCnt",   stallCnt,   m_cnt);
   endtask

   task automatic adv();
      bit s;
      s = model_stall();
      @(posedge clk);
      #1;
      if (s && m_cnt < CNT_MAX) m_cnt++;
      if (m_rem > 0)            m_rem--;
      else if (mdS && !br)      m_rem = MD_LAT;
   endtask

   task automatic clear_inputs();
      rs = '0; rt = '0; exRt = '0;
      usesRt = 1'b0; memRd = 1'b0; br = 1'b0; mdS = 1'b0; mdReq = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      memRd = 1'b1; exRt = 5'd8; rs = 5'd8; br = 1'b1;
      #2;
      chk("rst_pcWrite",    pcWrite,    1);
      chk("rst_ifidWrite",  ifidWrite,  1);
      chk("rst_ifidFlush",  ifidFlush,  0);
      chk("rst_idexBubble", idexBubble, 0);
      chk("rst_mdBusy",     mdBusy,     0);
      chk("rst_mdDone",     mdDone,     0);
      chk("rst_stallCnt",   stallCnt,   0);
      clear_inputs();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      m_rem = 0;
      m_cnt = 0;
   endtask

   initial begin
      int exp_stalls;

      //           rs  rt  exRt uses mem br   pc ifid fl bub
      vecs[0] = '{5'd8, 5'd0, 5'd8, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[1] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[2] = '{5'd3, 5'd9, 5'd9, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{5'd3, 5'd9, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      vecs[4] = '{5'd8, 5'd0, 5'd8, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      vecs[5] = '{5'd8, 5'd0, 5'd8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      vecs[6] = '{5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      vecs[7] = '{5'd4, 5'd4, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

      @(posedge clk);
      #1;
      do_reset();

      // Single-cycle hazard vectors from the idle state.
      exp_stalls = 0;
      for (int i = 0; i < 8; i++) begin
         clear_inputs();
         rs = vecs[i].rs; rt = vecs[i].rt; exRt = vecs[i].ex_rt;
         usesRt = vecs[i].uses_rt; memRd = vecs[i].mem_rd; br = vecs[i].br;
         mdReq = (i == 7);
         settle();
         model_check();
         chk($sformatf("v%0d_pcWrite", i),    pcWrite,    vecs[i].e_pc);
         chk($sformatf("v%0d_ifidWrite", i),  ifidWrite,  vecs[i].e_ifid);
         chk($sformatf("v%0d_ifidFlush", i),  ifidFlush,  vecs[i].e_flush);
         chk($sformatf("v%0d_idexBubble", i), idexBubble, vecs[i].e_bub);
         if (!vecs[i].e_pc) exp_stalls++;
         adv();
      end
      clear_inputs();
      settle();
      chk("vec_stallCnt", stallCnt, exp_stalls);
      adv();

      // Mult/div with a dependent ID instruction held throughout.
      do_reset();
      mdS = 1'b1; mdReq = 1'b1;
      settle(); model_check();
      chk("md_T_busy", mdBusy, 0);
      adv();
      mdS = 1'b0;
      for (int k = 1; k <= MD_LAT + 1; k++) begin
         settle(); model_check();
         chk($sformatf("md_T%0d_busy", k),    mdBusy,  k <= MD_LAT);
         chk($sformatf("md_T%0d_done", k),    mdDone,  k == MD_LAT);
         chk($sformatf("md_T%0d_pcWrite", k), pcWrite, k >= MD_LAT);
         adv();
      end
      settle();
      chk("md_stallCnt", stallCnt, MD_LAT - 1);
      adv();

      // mdStart coinciding with a taken branch is dropped.
      clear_inputs();
      mdS = 1'b1; br = 1'b1;
      settle(); model_check();
      chk("mdbr_flush", ifidFlush, 1);
      adv();
      clear_inputs();
      settle(); model_check();
      chk("mdbr_busy", mdBusy, 0);
      adv();

      // Branch in the middle of MD_WAIT does not disturb the unit.
      mdS = 1'b1;
      settle(); model_check(); adv();
      mdS = 1'b0; mdReq = 1'b1;
      for (int k = 1; k <= MD_LAT; k++) begin
         br = (k == 2);
         settle(); model_check();
         if (k == 2) begin
            chk("mdbr2_flush",   ifidFlush, 1);
            chk("mdbr2_pcWrite", pcWrite,   1);
         end
         chk($sformatf("mdbr2_T%0d_done", k), mdDone, k == MD_LAT);
         adv();
      end
      clear_inputs();

      // Asynchronous reset in the second busy cycle.
      mdS = 1'b1;
      settle(); model_check(); adv();
      mdS = 1'b0; mdReq = 1'b1;
      settle(); model_check(); adv();
      settle(); model_check();
      rst_n = 1'b0;
      #1;
      chk("arst_busy",     mdBusy,     0);
      chk("arst_done",     mdDone,     0);
      chk("arst_pcWrite",  pcWrite,    1);
      chk("arst_bubble",   idexBubble, 0);
      chk("arst_stallCnt", stallCnt,   0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      m_rem = 0;
      m_cnt = 0;
      for (int k = 0; k < MD_LAT + 1; k++) begin
         settle(); model_check();
         chk("arst_post_done", mdDone, 0);
         chk("arst_post_busy", mdBusy, 0);
         adv();
      end
      clear_inputs();

      // Randomized traffic against the reference model.
      for (int c = 0; c < 1500; c++) begin
         rs     = 5'($urandom_range(0, 3));
         rt     = 5'($urandom_range(0, 3));
         exRt   = 5'($urandom_range(0, 3));
         usesRt = 1'($urandom_range(0, 1));
         memRd  = 1'($urandom_range(0, 1));
         br     = ($urandom_range(0, 5) == 0);
         mdReq  = 1'($urandom_range(0, 1));
         mdS    = (m_rem == 0) && ($urandom_range(0, 5) == 0);
         settle();
         model_check();
         adv();
      end

      // Saturation of the stall counter under a continuous load-use hazard.
      do_reset();
      memRd = 1'b1; exRt = 5'd8; rs = 5'd8;
      for (int c = 0; c < CNT_MAX - 1; c++) adv();
      settle();
      chk("sat_FFFE", stallCnt, CNT_MAX - 1);
      adv();
      settle();
      chk("sat_FFFF", stallCnt, CNT_MAX);
      for (int c = 0; c < 5; c++) adv();
      settle();
      chk("sat_hold", stallCnt, CNT_MAX);
      model_check();
      adv();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage MIPS core. It decides each cycle whether the PC and IF/ID register advance, whether IF/ID is flushed, and whether a bubble (all control bits zero) is injected into ID/EX. It detects load-use hazards, flushes on taken branches and tracks a multi-cycle multiply/divide unit so that dependent ID-stage instructions are held. It sits beside the ID stage, driving the write enables of PC, IF/ID and ID/EX.

## Interface
- MD_LATENCY, 32, cycles the mult/div unit is busy after start (legal range 2..255)
- STALL_CNT_W, 16, width of the saturating stall-cycle counter
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- idRs  in  5  ID-stage instr[25:21]
- idRt  in  5  ID-stage instr[20:16]
- idUsesRt  in  1  ID-stage instruction reads rt as a source
- exMemRead  in  1  MemRead bit currently in ID/EX
- exRt  in  5  rt (load destination) currently in ID/EX
- branchTaken  in  1  EX-stage branch resolved taken
- mdStart  in  1  EX-stage instruction is mult/div, one-cycle pulse
- mdIdReq  in  1  ID-stage instruction is mfhi/mflo/mult/div
- pcWrite  out  1  PC load enable
- ifidWrite  out  1  IF/ID load enable
- ifidFlush  out  1  IF/ID loads a NOP
- idexBubble  out  1  ID/EX control bits forced to 0
- mdBusy  out  1  mult/div unit occupied
- mdDone  out  1  last busy cycle, one-cycle pulse
- stallCnt  out  STALL_CNT_W  cycles with pcWrite=0, saturating

## Operation
- States: RUN, MD_WAIT. Reset -> RUN, md counter 0, stallCnt 0.
- While rst_n=0 outputs are forced: pcWrite=1, ifidWrite=1, ifidFlush=0, idexBubble=0, mdBusy=0, mdDone=0, stallCnt=0.
- loadUse = exMemRead & (exRt!=0) & (exRt==idRs | (idUsesRt & exRt==idRt)).
- mdHold = mdBusy & ~mdDone & mdIdReq.
- Priority, highest first:
  - branchTaken: ifidFlush=1, idexBubble=1, pcWrite=1, ifidWrite=1. loadUse and mdHold are ignored.
  - loadUse or mdHold: pcWrite=0, ifidWrite=0, idexBubble=1.
  - Otherwise: pcWrite=1, ifidWrite=1, no flush or bubble.
- RUN: if mdStart & ~branchTaken, load counter with MD_LATENCY-1 and go to MD_WAIT. If branchTaken and mdStart arrive together, mdStart is ignored.
- MD_WAIT: counter decrements each cycle. mdBusy=1. When the counter is 0, mdDone=1 and the next state is RUN.
- mdStart in MD_WAIT is illegal because mdHold blocks it. It is ignored and flagged by an assertion.
- branchTaken in MD_WAIT flushes younger instructions but does not cancel the mult/div, which is older.
- stallCnt increments on each cycle with pcWrite=0 and saturates at all-ones.

## Timing
- Hazard outputs are combinational from the inputs and the current state. Zero-cycle latency.
- A load-use stall lasts exactly 1 cycle. The load then moves to MEM and the condition clears.
- mdStart high in cycle T: mdBusy is high in cycles T+1..T+MD_LATENCY, and mdDone is high in cycle T+MD_LATENCY only.
- An ID-stage mfhi waiting on the unit advances in the mdDone cycle, because HI/LO is written at that edge.
- Reset asserted mid-MD_WAIT takes effect immediately (asynchronous). After release the block is in RUN and idle.
- stallCnt updates at the rising edge following the stalled cycle.

## Structure
- pipe_ctrl_pkg: state enum {RUN, MD_WAIT}, REG_ZERO=5'd0, helper function for the loadUse compare.
- Sub-module md_timer: down-counter with load, busy and done outputs. Width is $clog2(MD_LATENCY).
- The top level holds the FSM, the priority mux and stallCnt.

## Test plan
- Load-use: exMemRead=1, exRt=8, idRs=8 for 1 cycle -> pcWrite=0, ifidWrite=0, idexBubble=1 for 1 cycle, stallCnt=1. Repeat with exRt=0 -> no stall.
- rt dependency: exRt=9, idRt=9, idUsesRt=0 -> no stall. Same with idUsesRt=1 -> stall.
- Branch plus load-use in the same cycle -> ifidFlush=1, idexBubble=1, pcWrite=1, stallCnt unchanged.
- MD_LATENCY=4, mdStart at T, mdIdReq held high -> mdBusy high T+1..T+4, stall in T+1..T+3, mdDone at T+4, pcWrite=1 at T+4, stallCnt=3.
- mdStart and branchTaken together -> state stays RUN, mdBusy=0. A branch during MD_WAIT -> flush, and mdDone still fires on schedule.
- Reset at T+2 of MD_WAIT -> mdBusy=0 immediately, no mdDone, stallCnt=0. stallCnt driven past 2^16-1 stall cycles -> holds 16'hFFFF.
